auv_wb_sram: RTL



---
 rtl/auv_wb_sram.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/auv_wb_sram.sv
// Wishbone B4 pipelined slave driving a 16-bit asynchronous SRAM with programmable wait states.
// Optional range check and error response: define AUV_WB_SRAM_ERR_EN.
module auv_wb_sram #(
    parameter int ADDR_WIDTH  = 24,
    parameter int SRAM_AW     = 18,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [15:0]           wb_dat_i,
    output logic [15:0]           wb_dat_o,
    input  logic [1:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_cyc_i,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_stall_o,
    output logic [SRAM_AW-1:0]    sram_adr_o,
    output logic [15:0]           sram_dq_o,
    input  logic [15:0]           sram_dq_i,
    output logic                  sram_dq_oe,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic                  sram_lb_n,
    output logic                  sram_ub_n
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic [1:0] sel_q;
    logic       we_q;
    logic       accept;
    logic       latch_read;
    logic       ack_next, ce_n_next, oe_n_next, we_n_next, lb_n_next, ub_n_next, dq_oe_next;

    assign wb_stall_o = (state != IDLE);
    assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;

`ifdef AUV_WB_SRAM_ERR_EN
    logic out_of_range;
    logic err_q, err_next;
    logic unused_adr;

    assign out_of_range = |wb_adr_i[ADDR_WIDTH-1:SRAM_AW+1];
    assign unused_adr   = wb_adr_i[0];
    assign wb_err_o     = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_next;
    end
`else
    // Upper address bits are deliberately ignored: the SRAM aliases across the byte space.
    logic unused_adr;
    assign unused_adr = ^{wb_adr_i[ADDR_WIDTH-1:SRAM_AW+1], wb_adr_i[0]};
    assign wb_err_o   = 1'b0;
`endif

    // Outputs are computed for the state being entered and registered, so pins are glitch-free.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        state_next = state;
        cnt_next   = cnt;
        ack_next   = 1'b0;
        ce_n_next  = 1'b1;
        oe_n_next  = 1'b1;
        we_n_next  = 1'b1;
        lb_n_next  = 1'b1;
        ub_n_next  = 1'b1;
        dq_oe_next = 1'b0;
        latch_read = 1'b0;
`ifdef AUV_WB_SRAM_ERR_EN
        err_next   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef AUV_WB_SRAM_ERR_EN
                    if (out_of_range) begin
                        state_next = ERR;
                        err_next   = 1'b1;
                    end else
`endif
                    begin
                        state_next = ACCESS;
                        cnt_next   = 4'(WAIT_STATES);
                        ce_n_next  = 1'b0;
                        lb_n_next  = ~wb_sel_i[0];
                        ub_n_next  = ~wb_sel_i[1];
                        oe_n_next  = wb_we_i;
                        we_n_next  = ~wb_we_i;
                        dq_oe_next = wb_we_i;
                    end
                end
            end
            ACCESS: begin
                if (!wb_cyc_i) begin
                    state_next = IDLE;
                end else if (cnt == 4'd0) begin
                    // Strobes drop but lanes and data stay put for one hold cycle.
                    state_next = DONE;
                    ack_next   = 1'b1;
                    lb_n_next  = ~sel_q[0];
                    ub_n_next  = ~sel_q[1];
                    dq_oe_next = we_q;
                    latch_read = ~we_q;
                end else begin
                    cnt_next   = cnt - 4'd1;
                    ce_n_next  = 1'b0;
                    lb_n_next  = ~sel_q[0];
                    ub_n_next  = ~sel_q[1];
                    oe_n_next  = we_q;
                    we_n_next  = ~we_q;
                    dq_oe_next = we_q;
                end
            end
            DONE:    state_next = IDLE;
`ifdef AUV_WB_SRAM_ERR_EN
            ERR:     state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            sel_q      <= 2'b00;
            we_q       <= 1'b0;
            wb_ack_o   <= 1'b0;
            wb_dat_o   <= 16'h0000;
            sram_adr_o <= '0;
            sram_dq_o  <= 16'h0000;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            wb_ack_o   <= ack_next;
            sram_dq_oe <= dq_oe_next;
            sram_ce_n  <= ce_n_next;
            sram_oe_n  <= oe_n_next;
            sram_we_n  <= we_n_next;
            sram_lb_n  <= lb_n_next;
            sram_ub_n  <= ub_n_next;
            if (accept) begin
                sram_adr_o <= wb_adr_i[SRAM_AW:1];
                sram_dq_o  <= wb_dat_i;
                sel_q      <= wb_sel_i;
                we_q       <= wb_we_i;
            end
            if (latch_read) wb_dat_o <= sram_dq_i;
        end
    end

endmodule
